// File: rtl/avalon_dma_burst_splitter.sv
// avalon_dma_burst_splitter: splits one long DMA request into
// burst commands held on the master's user port until user_done.
//
// Ports:
//   ACLK, ARESETN       clock, async active-low reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_write/addr/words request direction, byte address, word count
//   busy, done          request in progress / 1-cycle completion pulse
//   burst_count         bursts issued for the current request
//   user_addr           burst byte address to the master
//   user_read_enable    read command to the master
//   user_write_enable   write command to the master
//   user_word_size      burst length in words to the master
//   user_done           master end-of-burst ack
//
// Optional: `SPLITTER_BOUNDARY_EN keeps bursts inside BOUNDARY.
module avalon_dma_burst_splitter #(
  parameter int C_AVM_ADDR_WIDTH = 32,
  parameter int C_AVM_DATA_WIDTH = 32,
  parameter int LEN_WIDTH        = 24,
  parameter int MAX_BURST        = 128,
  parameter int BOUNDARY         = 4096
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [C_AVM_ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]        req_words,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 burst_count,
  output logic [C_AVM_ADDR_WIDTH-1:0] user_addr,
  output logic                        user_read_enable,
  output logic                        user_write_enable,
  output logic [8:0]                  user_word_size,
  input  logic                        user_done
);

  localparam int AW     = C_AVM_ADDR_WIDTH;
  localparam int BPW    = C_AVM_DATA_WIDTH / 8;
  localparam int LG_BPW = $clog2(BPW);
  localparam int LG_BND = $clog2(BOUNDARY);
  localparam int BW     = LG_BND + 1;
  localparam int CW     = (LEN_WIDTH > BW) ? LEN_WIDTH : BW;

`ifdef SPLITTER_BOUNDARY_EN
  localparam bit BND_EN = 1'b1;
`else
  localparam bit BND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ISSUE,
    GAP
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [AW-1:0]        cur_addr;
  logic [AW-1:0]        cur_addr_n;
  logic [LEN_WIDTH-1:0] remain;
  logic [LEN_WIDTH-1:0] remain_n;
  logic                 dir;
  logic                 dir_n;
  logic                 busy_n;
  logic                 done_n;
  logic                 rd_n;
  logic                 wr_n;
  logic [AW-1:0]        uaddr_n;
  logic [8:0]           size_n;
  logic [15:0]          cnt_n;

  logic [AW-1:0]        mask;
  logic [BW-1:0]        room_b;
  logic [CW-1:0]        room_w;
  logic [CW-1:0]        rem_w;
  logic [CW-1:0]        max_w;
  logic [CW-1:0]        len_w;

  assign req_ready = (state == IDLE);
  assign mask      = ~AW'(BPW - 1);

  // Words left before the next BOUNDARY-aligned address.
  // cur_addr is word aligned, so the division is exact.
  always_comb begin
    room_b = BW'(BOUNDARY)
           - {1'b0, cur_addr[LG_BND-1:0]};
    room_w = CW'(room_b >> LG_BPW);
    rem_w  = CW'(remain);
    max_w  = CW'(MAX_BURST);
    len_w  = (rem_w < max_w) ? rem_w : max_w;
    if (BND_EN && (room_w < len_w)) begin
      len_w = room_w;
    end
  end

  always_comb begin
    state_n    = state;
    cur_addr_n = cur_addr;
    remain_n   = remain;
    dir_n      = dir;
    busy_n     = busy;
    done_n     = 1'b0;
    rd_n       = user_read_enable;
    wr_n       = user_write_enable;
    uaddr_n    = user_addr;
    size_n     = user_word_size;
    cnt_n      = burst_count;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          cur_addr_n = req_addr & mask;
          remain_n   = req_words;
          dir_n      = req_write;
          cnt_n      = '0;
          if (req_words == '0) begin
            done_n = 1'b1;
          end else begin
            busy_n  = 1'b1;
            state_n = CALC;
          end
        end
      end
      CALC: begin
        size_n  = 9'(len_w);
        uaddr_n = cur_addr;
        rd_n    = !dir;
        wr_n    = dir;
        state_n = ISSUE;
      end
      ISSUE: begin
        // Dropping the enable on the ack edge keeps the
        // master from seeing a second command.
        if (user_done) begin
          rd_n       = 1'b0;
          wr_n       = 1'b0;
          cur_addr_n = cur_addr
                     + (AW'(user_word_size) << LG_BPW);
          remain_n   = remain
                     - LEN_WIDTH'(user_word_size);
          cnt_n      = burst_count + 16'd1;
          state_n    = GAP;
        end
      end
      GAP: begin
        if (remain != '0) begin
          state_n = CALC;
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state             <= IDLE;
      cur_addr          <= '0;
      remain            <= '0;
      dir               <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      user_read_enable  <= 1'b0;
      user_write_enable <= 1'b0;
      user_addr         <= '0;
      user_word_size    <= '0;
      burst_count       <= '0;
    end else begin
      state             <= state_n;
      cur_addr          <= cur_addr_n;
      remain            <= remain_n;
      dir               <= dir_n;
      busy              <= busy_n;
      done              <= done_n;
      user_read_enable  <= rd_n;
      user_write_enable <= wr_n;
      user_addr         <= uaddr_n;
      user_word_size    <= size_n;
      burst_count       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_avalon_dma_burst_splitter.sv
// tb_avalon_dma_burst_splitter: directed vectors for the
// burst splitter, plus reset and back-to-back sequences.
module tb_avalon_dma_burst_splitter;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [23:0] req_words = '0;
  logic        user_done = 1'b0;
  logic        req_ready;
  logic        busy;
  logic        done;
  logic [15:0] burst_count;
  logic [31:0] user_addr;
  logic        user_read_enable;
  logic        user_write_enable;
  logic [8:0]  user_word_size;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 ACLK = ~ACLK;

  avalon_dma_burst_splitter dut (
    .ACLK              (ACLK),
    .ARESETN           (ARESETN),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_words         (req_words),
    .busy              (busy),
    .done              (done),
    .burst_count       (burst_count),
    .user_addr         (user_addr),
    .user_read_enable  (user_read_enable),
    .user_write_enable (user_write_enable),
    .user_word_size    (user_word_size),
    .user_done         (user_done)
  );

  typedef struct packed {
    logic             wr;
    logic [31:0]      addr;
    logic [23:0]      words;
    logic [2:0]       n;
    logic [2:0][31:0] ba;
    logic [2:0][8:0]  bs;
    logic [7:0]       hold;
    logic             chain;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(
    input logic wr, input logic [31:0] addr,
    input logic [23:0] words, input int n,
    input logic [31:0] a0, input int s0,
    input logic [31:0] a1, input int s1,
    input logic [31:0] a2, input int s2,
    input int hold, input logic chain);
    vec_t v;
    v.wr    = wr;
    v.addr  = addr;
    v.words = words;
    v.n     = 3'(n);
    v.ba[0] = a0;
    v.ba[1] = a1;
    v.ba[2] = a2;
    v.bs[0] = 9'(s0);
    v.bs[1] = 9'(s1);
    v.bs[2] = 9'(s2);
    v.hold  = 8'(hold);
    v.chain = chain;
    return v;
  endfunction

  task automatic step();
    @(negedge ACLK);
  endtask

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  always @(negedge ACLK) begin
    n_chk++;
    if (user_read_enable && user_write_enable) begin
      n_fail++;
      $display("FAIL both_enables: got rd=1 wr=1, expected one-hot");
    end
  end

  task automatic wait_en(input int id, input int exp_c);
    int c = 0;
    do begin
      step();
      c++;
    end while (!(user_read_enable || user_write_enable)
               && c < 20);
    check($sformatf("v%0d_en_latency", id), c, exp_c);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [31:0] a0;
    logic [8:0]  s0;
    logic        r0;
    logic        w0;
    logic        stable;
    check($sformatf("v%0d_ready_idle", id), req_ready, 1);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_words = v.words;
    step();
    if (!v.chain) req_valid = 1'b0;
    if (v.n == 0) begin
      req_valid = 1'b0;
      check($sformatf("v%0d_zero_done", id), done, 1);
      check($sformatf("v%0d_zero_busy", id), busy, 0);
      check($sformatf("v%0d_zero_ready", id), req_ready, 1);
      check($sformatf("v%0d_zero_en", id),
            {user_read_enable, user_write_enable}, 0);
      step();
      check($sformatf("v%0d_zero_done_end", id), done, 0);
      check($sformatf("v%0d_zero_en2", id),
            {user_read_enable, user_write_enable}, 0);
      return;
    end
    check($sformatf("v%0d_start_busy", id), busy, 1);
    check($sformatf("v%0d_start_ready", id), req_ready, 0);
    check($sformatf("v%0d_start_done", id), done, 0);
    check($sformatf("v%0d_start_count", id), burst_count, 0);
    for (int b = 0; b < int'(v.n); b++) begin
      wait_en(id, (b == 0) ? 1 : 2);
      check($sformatf("v%0d_b%0d_addr", id, b),
            user_addr, v.ba[b]);
      check($sformatf("v%0d_b%0d_size", id, b),
            user_word_size, v.bs[b]);
      check($sformatf("v%0d_b%0d_wr", id, b),
            user_write_enable, v.wr);
      check($sformatf("v%0d_b%0d_rd", id, b),
            user_read_enable, !v.wr);
      a0 = user_addr;
      s0 = user_word_size;
      r0 = user_read_enable;
      w0 = user_write_enable;
      stable = 1'b1;
      for (int h = 0; h < int'(v.hold); h++) begin
        step();
        if (user_addr !== a0 || user_word_size !== s0 ||
            user_read_enable !== r0 ||
            user_write_enable !== w0 ||
            req_ready !== 1'b0)
          stable = 1'b0;
      end
      check($sformatf("v%0d_b%0d_stable", id, b), stable, 1);
      user_done = 1'b1;
      step();
      user_done = 1'b0;
      check($sformatf("v%0d_b%0d_en_after_ack", id, b),
            {user_read_enable, user_write_enable}, 0);
      check($sformatf("v%0d_b%0d_count", id, b),
            burst_count, b + 1);
    end
    check($sformatf("v%0d_gap_done", id), done, 0);
    check($sformatf("v%0d_gap_busy", id), busy, 1);
    step();
    check($sformatf("v%0d_done_pulse", id), done, 1);
    check($sformatf("v%0d_end_busy", id), busy, 0);
    check($sformatf("v%0d_end_ready", id), req_ready, 1);
    check($sformatf("v%0d_end_count", id), burst_count, v.n);
    if (v.chain) return;
    step();
    check($sformatf("v%0d_done_end", id), done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1'b0, 32'h1000, 300, 3,
                 32'h1000, 128, 32'h1200, 128,
                 32'h1400, 44, 2, 1'b0);
    vecs[1] = mk(1'b1, 32'h1234, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 1'b0);
`ifdef SPLITTER_BOUNDARY_EN
    vecs[2] = mk(1'b1, 32'h0FF0, 20, 2,
                 32'h0FF0, 4, 32'h1000, 16,
                 0, 0, 1, 1'b0);
`else
    vecs[2] = mk(1'b1, 32'h0FF0, 20, 1,
                 32'h0FF0, 20, 0, 0,
                 0, 0, 1, 1'b0);
`endif
    vecs[3] = mk(1'b1, 32'h3000, 130, 2,
                 32'h3000, 128, 32'h3200, 2,
                 0, 0, 50, 1'b0);
    vecs[4] = mk(1'b0, 32'h0103, 1, 1,
                 32'h0100, 1, 0, 0,
                 0, 0, 0, 1'b0);
    vecs[5] = mk(1'b1, 32'h8000, 128, 1,
                 32'h8000, 128, 0, 0,
                 0, 0, 1, 1'b0);
    vecs[6] = mk(1'b1, 32'h0500, 5, 1,
                 32'h0500, 5, 0, 0,
                 0, 0, 3, 1'b1);
`ifdef SPLITTER_BOUNDARY_EN
    vecs[7] = mk(1'b0, 32'hFFFFFFC0, 160, 3,
                 32'hFFFFFFC0, 16, 32'h0, 128,
                 32'h200, 16, 0, 1'b0);
`else
    vecs[7] = mk(1'b0, 32'hFFFFFFC0, 160, 2,
                 32'hFFFFFFC0, 128, 32'h1C0, 32,
                 0, 0, 0, 1'b0);
`endif

    repeat (3) step();
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", {user_read_enable, user_write_enable}, 0);
    check("rst_addr", user_addr, 0);
    check("rst_size", user_word_size, 0);
    check("rst_count", burst_count, 0);
    ARESETN = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
    run_vec(6, vecs[6]);
    run_vec(7, vecs[7]);

    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h2000;
    req_words = 300;
    step();
    req_valid = 1'b0;
    wait_en(20, 1);
    user_done = 1'b1;
    step();
    user_done = 1'b0;
    wait_en(20, 2);
    check("rst2_pre_en", user_read_enable, 1);
    check("rst2_pre_addr", user_addr, 32'h2200);
    #2 ARESETN = 1'b0;
    #1;
    check("rst2_en", {user_read_enable, user_write_enable}, 0);
    check("rst2_busy", busy, 0);
    check("rst2_done", done, 0);
    check("rst2_ready", req_ready, 1);
    check("rst2_count", burst_count, 0);
    step();
    ARESETN = 1'b1;
    step();
    check("rst2_post_ready", req_ready, 1);
    check("rst2_post_en",
          {user_read_enable, user_write_enable}, 0);
    run_vec(21, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
